// File: rtl/backing_mem_responder_if.sv
// Request/response channel between the data cache (master) and the backing memory
// responder (slave): one word request, one word response, each under valid/ready.
interface backing_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_we;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_rdata
  );
endinterface

// File: rtl/backing_mem_responder.sv
// Backing memory for the cache refill path: accepts one word access, holds it for a fixed
// latency, commits it to a word-addressed RAM and returns the response under valid/ready.
module backing_mem_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  backing_mem_responder_if.slave   bus,
  output logic                     busy
);

  localparam int CW    = $clog2(LATENCY + 1);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic accept;
  logic commit;
  logic unused_addr_bits;

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign commit = (state_q == ST_WAIT) && (cnt_q == CW'(1));

  // Only the word index selects a location; byte offset and upper bits alias.
  assign unused_addr_bits = ^{bus.req_addr[31:ADDRESS_WIDTH+2], bus.req_addr[1:0]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          // Counter starts at LATENCY so the commit edge lands LATENCY edges after accept.
          cnt_d   = CW'(LATENCY);
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[ADDRESS_WIDTH+1:2];
          wdata_d = bus.req_wdata;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (commit) begin
          state_d = ST_RESP;
          rdata_d = we_q ? '0 : mem[idx_q];
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the RAM array has no reset; its contents must survive rst, and commit is low in reset.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_we    = we_q;
  assign bus.resp_rdata = rdata_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_backing_mem_responder.sv
// Directed bench for backing_mem_responder: a LATENCY=4 instance and a LATENCY=1 instance
// share one request driver; sel chooses which one the transaction tasks talk to.
module tb_backing_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        busy0, busy1;

  backing_mem_responder_if #(.DATA_WIDTH(32)) bus0 ();
  backing_mem_responder_if #(.DATA_WIDTH(32)) bus1 ();

  backing_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(4)) dut (
    .clk (clk), .rst (rst), .bus (bus0), .busy (busy0)
  );
  backing_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1), .busy (busy1)
  );

  assign bus0.req_valid  = req_valid & ~sel;
  assign bus1.req_valid  = req_valid & sel;
  assign bus0.req_we     = req_we;
  assign bus1.req_we     = req_we;
  assign bus0.req_addr   = req_addr;
  assign bus1.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;
  assign bus1.req_wdata  = req_wdata;
  assign bus0.resp_ready = resp_ready & ~sel;
  assign bus1.resp_ready = resp_ready & sel;

  logic        obs_ready, obs_valid, obs_we, obs_busy;
  logic [31:0] obs_rdata;
  assign obs_ready = sel ? bus1.req_ready  : bus0.req_ready;
  assign obs_valid = sel ? bus1.resp_valid : bus0.resp_valid;
  assign obs_we    = sel ? bus1.resp_we    : bus0.resp_we;
  assign obs_rdata = sel ? bus1.resp_rdata : bus0.resp_rdata;
  assign obs_busy  = sel ? busy1 : busy0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: present, wait for accept, count edges to resp_valid, handshake.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rwe, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
    guard = 0;
    while (!obs_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", obs_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!obs_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rd  = obs_rdata;
    rwe = obs_we;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_after_hs", obs_valid, 0);
  endtask

  logic [31:0] rd;
  logic        rwe;
  int          lat, guard, low, vrun, nlow;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    #12;
    check("rst_valid0", bus0.resp_valid, 0);
    check("rst_we0",    bus0.resp_we, 0);
    check("rst_rdata0", bus0.resp_rdata, 0);
    check("rst_busy0",  busy0, 0);
    check("rst_valid1", bus1.resp_valid, 0);
    check("rst_busy1",  busy1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready0", bus0.req_ready, 1);
    check("rel_ready1", bus1.req_ready, 1);

    // Write then read back with LATENCY=4.
    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, rwe, lat);
    check("wr_latency", lat, 4);
    check("wr_resp_we", rwe, 1);
    check("wr_rdata",   rd, 0);
    xact(1'b0, 32'h10, 32'h0, rd, rwe, lat);
    check("rd_latency", lat, 4);
    check("rd_resp_we", rwe, 0);
    check("rd_rdata",   rd, 32'hDEADBEEF);

    // Back-to-back reads with resp_ready tied high: 5 cycles not-ready, 1-cycle responses.
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    check("b2b_start_ready", obs_ready, 1);
    low = 0; vrun = 0; nlow = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!obs_ready) low++;
      else if (low != 0) begin
        check("b2b_ready_low_cycles", low, 5);
        low = 0;
        nlow++;
      end
      if (obs_valid) begin
        vrun++;
        check("b2b_rdata", obs_rdata, 32'hDEADBEEF);
      end else if (vrun != 0) begin
        check("b2b_valid_width", vrun, 1);
        vrun = 0;
      end
    end
    check("b2b_requests", nlow, 3);
    req_valid = 1'b0;
    guard = 0;
    while (obs_busy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_drain", obs_busy, 0);
    resp_ready = 1'b0;

    // Response held for 10 cycles; a second request during RESP must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    check("hold_accept_ready", obs_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!obs_valid && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("hold_valid_seen", obs_valid, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", obs_valid, 1);
      check("hold_rdata", obs_rdata, 32'hDEADBEEF);
      check("hold_ready", obs_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_released", obs_valid, 0);
    xact(1'b0, 32'h10, 32'h0, rd, rwe, lat);
    check("ignored_write", rd, 32'hDEADBEEF);

    // Index wrap: 0x404 aliases 0x004.
    xact(1'b1, 32'h004, 32'h12345678, rd, rwe, lat);
    xact(1'b0, 32'h404, 32'h0, rd, rwe, lat);
    check("wrap_rdata", rd, 32'h12345678);

    // Reset during WAIT drops the pending write; earlier RAM contents survive.
    xact(1'b1, 32'h20, 32'h5A5A0001, rd, rwe, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    check("rst_mid_accept", obs_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", obs_busy, 1);
    check("rst_mid_we",   obs_we, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", obs_valid, 0);
    check("rst_mid_busy0", obs_busy, 0);
    check("rst_mid_we0",   obs_we, 0);
    check("rst_mid_rdata", obs_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", obs_ready, 1);
    xact(1'b0, 32'h20, 32'h0, rd, rwe, lat);
    check("rst_dropped_write", rd, 32'h5A5A0001);
    xact(1'b0, 32'h10, 32'h0, rd, rwe, lat);
    check("rst_ram_retained", rd, 32'hDEADBEEF);

    // LATENCY=1 instance.
    sel = 1'b1;
    xact(1'b1, 32'h30, 32'hCAFEF00D, rd, rwe, lat);
    check("l1_wr_latency", lat, 1);
    check("l1_wr_resp_we", rwe, 1);
    check("l1_wr_rdata",   rd, 0);
    xact(1'b0, 32'h30, 32'h0, rd, rwe, lat);
    check("l1_rd_latency", lat, 1);
    check("l1_rd_rdata",   rd, 32'hCAFEF00D);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
